// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: boot-image load, then per-cycle fetch.
// Optional macro FETCH_BOUNDS_CHECK_EN enables redirect/PC bounds faulting.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  input  logic [31:0] imem_instr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [1:0]  state,
  output logic        fetch_fault
);

  localparam int CW = $clog2(MEM_WORDS + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;

  logic [31:0] load_addr;
  logic [31:0] tgt;
  logic [31:0] cand;
  logic        bad;

  assign load_addr = RESET_PC + (32'(cnt_q) << 2);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] LIMIT =
    {1'b0, RESET_PC} + 33'(MEM_WORDS) * 33'd4;

  always_comb begin
    tgt  = redirect_pc;
    cand = redirect_valid ? tgt : pc_q + 32'd4;
    bad  = (redirect_valid && (tgt[1:0] != 2'b00))
        || ({1'b0, cand} >= LIMIT);
  end
`else
  always_comb begin
    tgt  = redirect_pc & 32'hFFFF_FFFC;
    cand = redirect_valid ? tgt : pc_q + 32'd4;
    bad  = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_LOAD;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    load_ready  = 1'b0;
    imem_we     = 1'b0;
    imem_addr   = pc_q;
    instr_valid = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_LOAD: begin
          load_ready = 1'b1;
          imem_we    = load_valid;
          imem_addr  = load_addr;
          if (load_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (load_last || cnt_q == CW'(MEM_WORDS - 1))
              state_d = S_RUN;
          end
        end
        S_RUN: begin
          instr_valid = ~stall;
          if (halt_req) begin
            state_d = S_HALT;
          end else if (redirect_valid || !stall) begin
            // A rejected target is never loaded into the PC.
            if (bad) begin
              fault_d = 1'b1;
              state_d = S_HALT;
            end else begin
              pc_d = cand;
            end
          end
        end
        S_HALT: ;
        default: state_d = S_LOAD;
      endcase
    end
  end

  assign imem_wdata  = load_data;
  assign instr       = instr_valid ? imem_instr : NOP;
  assign pc          = pc_q;
  assign state       = state_q;
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized bench for imem_fetch_ctrl against a behavioural fetch model.
// Build with FETCH_BOUNDS_CHECK_EN to exercise the bounds-checked variant.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          MW  = 256;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] imem_instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic [1:0]  state;
  logic        fetch_fault;

  imem_fetch_ctrl #(
    .RESET_PC (RPC),
    .MEM_WORDS(MW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_data     (load_data),
    .load_last     (load_last),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .imem_instr    (imem_instr),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .pc            (pc),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .state         (state),
    .fetch_fault   (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural InstructionMemory: async read, write on clock edge.
  logic [31:0] mem [0:255];
  always @(posedge clk)
    if (imem_we) mem[imem_addr[9:2]] <= imem_wdata;
  assign imem_instr = mem[imem_addr[9:2]];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 = loading, 1 = running, 2 = halted.
  int          m_st;
  logic [31:0] m_pc;
  int          m_cnt;
  logic        m_f;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit lv, input bit ll,
                      input bit st, input bit rv, input bit hr,
                      input logic [31:0] rpc);
    logic [31:0] c;
    longint      lim;
    @(negedge clk);
    rst            = r;
    load_valid     = lv;
    load_last      = ll;
    load_data      = $urandom;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = hr;
    #1;
    if (r) begin
      check("rst_ready", 32'(load_ready), 0);
      check("rst_we", 32'(imem_we), 0);
      check("rst_valid", 32'(instr_valid), 0);
      check("rst_instr", instr, NOP);
    end else begin
      check("state", 32'(state), 32'(m_st));
      check("pc", pc, m_pc);
      check("fault", 32'(fetch_fault), 32'(m_f));
      if (m_st == 0) begin
        check("ld_ready", 32'(load_ready), 1);
        check("ld_we", 32'(imem_we), 32'(lv));
        check("ld_addr", imem_addr, RPC + 32'(4 * m_cnt));
        check("ld_valid", 32'(instr_valid), 0);
        check("ld_instr", instr, NOP);
      end else if (m_st == 1) begin
        check("run_ready", 32'(load_ready), 0);
        check("run_we", 32'(imem_we), 0);
        check("run_addr", imem_addr, m_pc);
        check("run_valid", 32'(instr_valid), 32'(!st));
        check("run_instr", instr, st ? NOP : mem[m_pc[9:2]]);
      end else begin
        check("hlt_ready", 32'(load_ready), 0);
        check("hlt_we", 32'(imem_we), 0);
        check("hlt_valid", 32'(instr_valid), 0);
        check("hlt_instr", instr, NOP);
      end
    end
    if (r) begin
      m_st = 0; m_pc = RPC; m_cnt = 0; m_f = 1'b0;
    end else if (m_st == 0) begin
      if (lv) begin
        if (ll || m_cnt == MW - 1) m_st = 1;
        m_cnt++;
      end
    end else if (m_st == 1) begin
      if (hr) begin
        m_st = 2;
      end else if (rv || !st) begin
        c = rv ? rpc : m_pc + 32'd4;
`ifdef FETCH_BOUNDS_CHECK_EN
        lim = longint'(RPC) + 4 * MW;
        if (c % 4 != 0 || longint'(c) >= lim) begin
          m_f = 1'b1; m_st = 2;
        end else begin
          m_pc = c;
        end
`else
        lim = 0;
        m_pc = c / 4 * 4;
`endif
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, $urandom % 2, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_load(input int n);
    int  w;
    bit  lv;
    w = 0;
    while (w < n) begin
      lv = ($urandom % 4) != 0;
      step(0, lv, lv && (w == n - 1), $urandom % 2, $urandom % 2,
           $urandom % 2, $urandom);
      if (lv) w++;
    end
  endtask

  function automatic logic [31:0] rand_tgt();
    int k;
    k = $urandom % 10;
    if (k < 7) return RPC + 32'($urandom_range(0, MW - 1) * 4);
    if (k == 7) return RPC + 32'($urandom_range(0, MW - 1) * 4 + 1);
    if (k == 8) return RPC + 32'(MW * 4) + 32'($urandom % 64);
    return $urandom;
  endfunction

  task automatic rand_run(input int n);
    for (int i = 0; i < n; i++)
      step(0, $urandom % 2, $urandom % 2, ($urandom % 4) == 0,
           ($urandom % 8) == 0, ($urandom % 40) == 0, rand_tgt());
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    halt_req = 1'b0;
    m_st = 0; m_pc = RPC; m_cnt = 0; m_f = 1'b0;

    // Three-word image, then sequential fetch with a stall at 0x8.
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0);
    idle(2);
    // Redirect beats stall; then halt and stay frozen.
    step(0, 0, 0, 1, 1, 0, 32'h40);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0, 32'h80);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    // Gapped load, then misaligned / out-of-range / wrapping targets.
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'h42);
    idle(2);
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC);
    idle(2);
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, RPC + 32'(MW * 4 - 4));
    idle(2);

    // Reset mid-load restarts the image at RESET_PC.
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    do_reset();
    step(0, 1, 1, 0, 0, 0, 0);
    idle(1);

    // Full-depth image without load_last ends at the last word.
    do_reset();
    for (int i = 0; i < MW; i++) step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    idle(2);

    for (int k = 0; k < 30; k++) begin
      do_reset();
      rand_load($urandom_range(1, 16));
      rand_run(40);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
